// File: rtl/param_regfile_if.sv
// param_regfile_if: write, dual-read and scoreboard-reserve signals of the register file
interface param_regfile_if #(parameter int WIDTH = 16, parameter int DEPTH = 8);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [NB-1:0]    wr_be;
    logic [AW-1:0]    rd0_addr;
    logic [AW-1:0]    rd1_addr;
    logic [WIDTH-1:0] rd0_data;
    logic [WIDTH-1:0] rd1_data;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             rd0_busy;
    logic             rd1_busy;
    logic             rsv_ok;
    logic [DEPTH-1:0] busy;
    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd0_addr, rd1_addr, rsv_en, rsv_addr,
        input  rd0_data, rd1_data, rd0_busy, rd1_busy, rsv_ok, busy
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd0_addr, rd1_addr, rsv_en, rsv_addr,
        output rd0_data, rd1_data, rd0_busy, rd1_busy, rsv_ok, busy
    );
endinterface

// File: rtl/param_regfile.sv
// param_regfile: byte-enabled 2R1W register file with pending-write scoreboard
// Optional REGFILE_BYPASS_EN forwards same-cycle write data/busy-clear to the read ports.
module param_regfile #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1
) (
    input logic            clk,
    input logic            rst,
    param_regfile_if.slave bus
);
    localparam int NB = WIDTH / 8;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy_q, clr, set;
    logic [WIDTH-1:0] merged, raw0, raw1;
    logic             wr_zero, rsv_zero, hit0, hit1;
    assign wr_zero  = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign rsv_zero = (ZERO_REG != 0) && (bus.rsv_addr == '0);
    assign bus.rsv_ok = bus.rsv_en & ~busy_q[bus.rsv_addr] & ~rsv_zero;
    always_comb begin
        merged = mem[bus.wr_addr];
        for (int b = 0; b < NB; b++)
            merged[8*b +: 8] = bus.wr_be[b] ? bus.wr_data[8*b +: 8] : mem[bus.wr_addr][8*b +: 8];
    end
    always_comb begin
        clr = '0;
        set = '0;
        clr[bus.wr_addr]  = bus.wr_en;
        set[bus.rsv_addr] = bus.rsv_ok;
    end
    // set after clear so a same-address reserve outlives the write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy_q <= '0;
        end else begin
            if (bus.wr_en && !wr_zero) mem[bus.wr_addr] <= merged;
            busy_q <= ((busy_q & ~clr) | set) & ~{{(DEPTH-1){1'b0}}, ZERO_REG != 0};
        end
    end
    assign raw0 = ((ZERO_REG != 0) && bus.rd0_addr == '0) ? '0 : mem[bus.rd0_addr];
    assign raw1 = ((ZERO_REG != 0) && bus.rd1_addr == '0) ? '0 : mem[bus.rd1_addr];
`ifdef REGFILE_BYPASS_EN
    assign hit0 = bus.wr_en && !wr_zero && (bus.rd0_addr == bus.wr_addr);
    assign hit1 = bus.wr_en && !wr_zero && (bus.rd1_addr == bus.wr_addr);
`else
    assign hit0 = 1'b0;
    assign hit1 = 1'b0;
`endif
    assign bus.rd0_data = hit0 ? merged : raw0;
    assign bus.rd1_data = hit1 ? merged : raw1;
    assign bus.rd0_busy = busy_q[bus.rd0_addr] & ~hit0;
    assign bus.rd1_busy = busy_q[bus.rd1_addr] & ~hit1;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: table-driven directed checks of param_regfile (WIDTH=16, DEPTH=8, ZERO_REG=1)
module tb_param_regfile;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        logic        rst, we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        re;
        logic [2:0]  ra, a0, a1;
        logic [15:0] e0, e1;
        logic [7:0]  eb;
        logic        eok, eb0, eb1;
    } vec_t;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    vec_t v [15];
    param_regfile_if #(.WIDTH(16), .DEPTH(8)) bus ();
    param_regfile #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask
    task automatic drive(input vec_t x);
        rst          = x.rst;
        bus.wr_en    = x.we;
        bus.wr_addr  = x.wa;
        bus.wr_data  = x.wd;
        bus.wr_be    = x.be;
        bus.rsv_en   = x.re;
        bus.rsv_addr = x.ra;
        bus.rd0_addr = x.a0;
        bus.rd1_addr = x.a1;
    endtask
    initial begin
        //         rst   we   wa    wd       be     re   ra    a0    a1    e0                       e1                       eb     eok  eb0        eb1
        v[0]  = '{1'b0,1'b1,3'd3,16'hBEEF,2'b11,1'b0,3'd0,3'd3,3'd0,BYP?16'hBEEF:16'h0000, 16'h0000,                8'h00,1'b0,1'b0,      1'b0};
        v[1]  = '{1'b1,1'b1,3'd5,16'h1111,2'b11,1'b1,3'd2,3'd3,3'd0,16'hBEEF,                16'h0000,                8'h00,1'b1,1'b0,      1'b0};
        v[2]  = '{1'b0,1'b0,3'd0,16'h0000,2'b00,1'b1,3'd0,3'd3,3'd5,16'h0000,                16'h0000,                8'h00,1'b0,1'b0,      1'b0};
        v[3]  = '{1'b0,1'b1,3'd5,16'h1234,2'b11,1'b0,3'd0,3'd5,3'd2,BYP?16'h1234:16'h0000, 16'h0000,                8'h00,1'b0,1'b0,      1'b0};
        v[4]  = '{1'b0,1'b1,3'd5,16'hABCD,2'b01,1'b0,3'd0,3'd5,3'd5,BYP?16'h12CD:16'h1234, BYP?16'h12CD:16'h1234, 8'h00,1'b0,1'b0,      1'b0};
        v[5]  = '{1'b0,1'b1,3'd0,16'hFFFF,2'b11,1'b0,3'd0,3'd5,3'd0,16'h12CD,                16'h0000,                8'h00,1'b0,1'b0,      1'b0};
        v[6]  = '{1'b0,1'b0,3'd0,16'h0000,2'b00,1'b1,3'd2,3'd0,3'd2,16'h0000,                16'h0000,                8'h00,1'b1,1'b0,      1'b0};
        v[7]  = '{1'b0,1'b0,3'd0,16'h0000,2'b00,1'b1,3'd2,3'd2,3'd5,16'h0000,                16'h12CD,                8'h04,1'b0,1'b1,      1'b0};
        v[8]  = '{1'b0,1'b1,3'd2,16'hFFFF,2'b00,1'b0,3'd0,3'd2,3'd0,16'h0000,                16'h0000,                8'h04,1'b0,BYP?1'b0:1'b1,1'b0};
        v[9]  = '{1'b0,1'b0,3'd0,16'h0000,2'b00,1'b1,3'd4,3'd2,3'd4,16'h0000,                16'h0000,                8'h00,1'b1,1'b0,      1'b0};
        v[10] = '{1'b0,1'b1,3'd4,16'h1111,2'b11,1'b0,3'd0,3'd4,3'd1,BYP?16'h1111:16'h0000, 16'h0000,                8'h10,1'b0,BYP?1'b0:1'b1,1'b0};
        v[11] = '{1'b0,1'b1,3'd4,16'h7777,2'b11,1'b1,3'd4,3'd4,3'd4,BYP?16'h7777:16'h1111, BYP?16'h7777:16'h1111, 8'h00,1'b1,1'b0,      1'b0};
        v[12] = '{1'b0,1'b1,3'd4,16'h8888,2'b10,1'b1,3'd1,3'd4,3'd1,BYP?16'h8877:16'h7777, 16'h0000,                8'h10,1'b1,BYP?1'b0:1'b1,1'b0};
        v[13] = '{1'b0,1'b1,3'd6,16'h5A5A,2'b11,1'b0,3'd0,3'd4,3'd6,16'h8877,                BYP?16'h5A5A:16'h0000, 8'h02,1'b0,1'b0,      1'b0};
        v[14] = '{1'b0,1'b0,3'd0,16'h0000,2'b00,1'b0,3'd0,3'd1,3'd6,16'h0000,                16'h5A5A,                8'h02,1'b0,1'b1,      1'b0};
        drive('{1'b1,1'b0,3'd0,16'h0,2'b0,1'b0,3'd0,3'd0,3'd0,16'h0,16'h0,8'h0,1'b0,1'b0,1'b0});
        repeat (2) @(negedge clk);
        #1;
        chk("reset rd0", bus.rd0_data, 16'h0000);
        chk("reset busy", {8'h00, bus.busy}, 16'h0000);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(v[i]);
            #1;
            chk($sformatf("v%0d rd0_data", i), bus.rd0_data, v[i].e0);
            chk($sformatf("v%0d rd1_data", i), bus.rd1_data, v[i].e1);
            chk($sformatf("v%0d busy", i), {8'h00, bus.busy}, {8'h00, v[i].eb});
            chk($sformatf("v%0d rsv_ok", i), {15'h0, bus.rsv_ok}, {15'h0, v[i].eok});
            chk($sformatf("v%0d rd0_busy", i), {15'h0, bus.rd0_busy}, {15'h0, v[i].eb0});
            chk($sformatf("v%0d rd1_busy", i), {15'h0, bus.rd1_busy}, {15'h0, v[i].eb1});
        end
        // reset with a pending bit, plus a coincident reserve, must clear the whole scoreboard
        @(negedge clk);
        drive('{1'b0,1'b0,3'd0,16'h0,2'b0,1'b1,3'd7,3'd1,3'd7,16'h0,16'h0,8'h0,1'b0,1'b0,1'b0});
        @(negedge clk);
        drive('{1'b1,1'b0,3'd0,16'h0,2'b0,1'b1,3'd3,3'd4,3'd6,16'h0,16'h0,8'h0,1'b0,1'b0,1'b0});
        #1;
        chk("pre-rst busy", {8'h00, bus.busy}, 16'h0082);
        @(negedge clk);
        drive('{1'b0,1'b0,3'd0,16'h0,2'b0,1'b1,3'd7,3'd4,3'd6,16'h0,16'h0,8'h0,1'b0,1'b0,1'b0});
        #1;
        chk("post-rst busy", {8'h00, bus.busy}, 16'h0000);
        chk("post-rst rd0", bus.rd0_data, 16'h0000);
        chk("post-rst rd1", bus.rd1_data, 16'h0000);
        chk("post-rst rsv_ok", {15'h0, bus.rsv_ok}, 16'h0001);
        @(negedge clk);
        #1;
        chk("rsv7 busy", {8'h00, bus.busy}, 16'h0080);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
